// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL opcode enums and the error-responder queue entry.
// Entry field widths are fixed here. The responder's SIZE_W/SRC_W defaults track them.
package tl_ul_pkg;

  localparam int unsigned TL_SIZE_W = 3;
  localparam int unsigned TL_SRC_W  = 4;

  typedef enum logic [2:0] {
    PUT_FULL    = 3'd0,
    PUT_PARTIAL = 3'd1,
    GET         = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    ACCESS_ACK      = 3'd0,
    ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  typedef struct packed {
    tl_d_op_e               op;
    logic [TL_SIZE_W-1:0]   size;
    logic [TL_SRC_W-1:0]    source;
  } tl_err_entry_t;

endpackage

// File: rtl/tl_err_resp_queue.sv
// DEPTH-entry FIFO of pending denied responses.
// The head entry stays queued until its last D beat pops it.
// full/empty are registered. The *_nxt_c outputs preview next-cycle state,
// so the D side can load the following head without a bubble.
module tl_err_resp_queue
  import tl_ul_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  tl_err_entry_t push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output tl_err_entry_t head_nxt_c,
  output logic          empty_nxt_c,
  output logic          full_nxt_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  tl_err_entry_t    mem_q [DEPTH];
  tl_err_entry_t    mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_left;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer, count and storage update, plus the next-cycle head preview
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    push_ok  = push & ~full_q;
    pop_ok   = pop & ~empty_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    // Entries already stored that survive this cycle's pop
    cnt_left    = cnt_q - CNT_W'(pop_ok);
    head_nxt_c  = (cnt_left != '0) ? mem_q[rd_ptr_d] : push_data;
    empty_nxt_c = (cnt_d == '0);
    full_nxt_c  = (cnt_d == CNT_W'(DEPTH));
  end

  // Queue state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_nxt_c;
      empty_q  <= empty_nxt_c;
    end
  end

  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/tl_ul_error_responder.sv
// TileLink-UL default-slot responder: every request gets a denied D response.
// Puts drain all A beats and then get one AccessAck. Gets get AccessAckData beats of zero
// data marked corrupt. Illegal opcodes get one AccessAck and an err_illegal pulse.
// Optional: define TL_ERR_RESP_COUNT_EN to add err_count, a saturating count of
// enqueued requests.
module tl_ul_error_responder
  import tl_ul_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned SRC_W  = TL_SRC_W,
  parameter int unsigned SIZE_W = TL_SIZE_W,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [2:0]        a_opcode,
  input  logic [SIZE_W-1:0] a_size,
  input  logic [SRC_W-1:0]  a_source,
  input  logic [ADDR_W-1:0] a_address,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [2:0]        d_opcode,
  output logic [SIZE_W-1:0] d_size,
  output logic [SRC_W-1:0]  d_source,
  output logic              d_denied,
  output logic              d_corrupt,
  output logic [DATA_W-1:0] d_data,
  output logic              err_illegal
`ifdef TL_ERR_RESP_COUNT_EN
  ,
  output logic [15:0]       err_count
`endif
);

  // Byte-offset bits covered by one data beat
  localparam int unsigned OFF_W  = $clog2(DATA_W / 8);
  // Wide enough for the beat index of the largest encodable size
  localparam int unsigned BEAT_W = 2 ** SIZE_W;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } d_state_e;

  // Index of the final beat: beats(size) - 1, where beats = max(1, 2^size / bytes-per-beat)
  function automatic logic [BEAT_W-1:0] beat_last(input logic [SIZE_W-1:0] size);
    if (32'(size) <= OFF_W) return '0;
    return (BEAT_W'(1) << (32'(size) - OFF_W)) - BEAT_W'(1);
  endfunction

  // A side
  logic              a_ready_q;
  logic              a_busy_q, a_busy_d;
  logic [BEAT_W-1:0] a_beat_q, a_beat_d;
  logic [BEAT_W-1:0] a_last_q, a_last_d;
  logic [SIZE_W-1:0] a_size_q, a_size_d;
  logic [SRC_W-1:0]  a_src_q, a_src_d;
  logic              err_illegal_q, err_illegal_d;
  logic              accept;
  logic              push;
  tl_err_entry_t     push_data;

  // Queue
  logic              q_push, q_pop;
  logic              q_full, q_empty;
  logic              q_empty_nxt, q_full_nxt;
  tl_err_entry_t     q_head_nxt;

  // D side
  d_state_e          state_q, state_d;
  logic              d_valid_q, d_valid_d;
  tl_d_op_e          d_opcode_q, d_opcode_d;
  logic [SIZE_W-1:0] d_size_q, d_size_d;
  logic [SRC_W-1:0]  d_source_q, d_source_d;
  logic              d_denied_q, d_denied_d;
  logic              d_corrupt_q, d_corrupt_d;
  logic [BEAT_W-1:0] d_beat_q, d_beat_d;
  logic [BEAT_W-1:0] d_last_q, d_last_d;
  logic              d_last_beat;
  logic              load;

  logic unused_addr;
  assign unused_addr = ^a_address;

  assign accept = a_valid & a_ready_q;

  // A-channel decode: multi-beat Put tracking and response enqueue
  always_comb begin
    a_busy_d         = a_busy_q;
    a_beat_d         = a_beat_q;
    a_last_d         = a_last_q;
    a_size_d         = a_size_q;
    a_src_d          = a_src_q;
    err_illegal_d    = 1'b0;
    push             = 1'b0;
    push_data.op     = ACCESS_ACK;
    push_data.size   = TL_SIZE_W'(a_size);
    push_data.source = TL_SRC_W'(a_source);
    if (accept) begin
      if (a_busy_q) begin
        // Trailing Put beats: header fields come from the first beat
        if (a_beat_q == a_last_q) begin
          push             = 1'b1;
          push_data.size   = TL_SIZE_W'(a_size_q);
          push_data.source = TL_SRC_W'(a_src_q);
          a_busy_d         = 1'b0;
          a_beat_d         = '0;
        end else begin
          a_beat_d = a_beat_q + BEAT_W'(1);
        end
      end else begin
        case (a_opcode)
          PUT_FULL, PUT_PARTIAL: begin
            if (beat_last(a_size) == '0) begin
              push = 1'b1;
            end else begin
              a_busy_d = 1'b1;
              a_beat_d = BEAT_W'(1);
              a_last_d = beat_last(a_size);
              a_size_d = a_size;
              a_src_d  = a_source;
            end
          end
          GET: begin
            push         = 1'b1;
            push_data.op = ACCESS_ACK_DATA;
          end
          default: begin
            push          = 1'b1;
            err_illegal_d = 1'b1;
          end
        endcase
      end
    end
  end

  // A-side registers. a_ready mirrors the queue's next full flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_ready_q     <= 1'b0;
      a_busy_q      <= 1'b0;
      a_beat_q      <= '0;
      a_last_q      <= '0;
      a_size_q      <= '0;
      a_src_q       <= '0;
      err_illegal_q <= 1'b0;
    end else begin
      a_ready_q     <= ~q_full_nxt;
      a_busy_q      <= a_busy_d;
      a_beat_q      <= a_beat_d;
      a_last_q      <= a_last_d;
      a_size_q      <= a_size_d;
      a_src_q       <= a_src_d;
      err_illegal_q <= err_illegal_d;
    end
  end

  assign q_push      = push & ~q_full;
  assign d_last_beat = (d_beat_q == d_last_q);
  assign q_pop       = (state_q == RESP) & d_ready & d_last_beat & ~q_empty;

  tl_err_resp_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clock       (clock),
    .reset_n     (reset_n),
    .push        (q_push),
    .push_data   (push_data),
    .pop         (q_pop),
    .full        (q_full),
    .empty       (q_empty),
    .head_nxt_c  (q_head_nxt),
    .empty_nxt_c (q_empty_nxt),
    .full_nxt_c  (q_full_nxt)
  );

  // D-channel FSM: load the next head into the output registers and count beats
  always_comb begin
    state_d     = state_q;
    d_valid_d   = d_valid_q;
    d_opcode_d  = d_opcode_q;
    d_size_d    = d_size_q;
    d_source_d  = d_source_q;
    d_denied_d  = d_denied_q;
    d_corrupt_d = d_corrupt_q;
    d_beat_d    = d_beat_q;
    d_last_d    = d_last_q;
    load        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!q_empty_nxt) load = 1'b1;
      end
      RESP: begin
        if (d_ready) begin
          if (d_last_beat) begin
            if (!q_empty_nxt) begin
              load = 1'b1;
            end else begin
              state_d     = IDLE;
              d_valid_d   = 1'b0;
              d_opcode_d  = ACCESS_ACK;
              d_size_d    = '0;
              d_source_d  = '0;
              d_denied_d  = 1'b0;
              d_corrupt_d = 1'b0;
              d_beat_d    = '0;
              d_last_d    = '0;
            end
          end else begin
            d_beat_d = d_beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d     = RESP;
      d_valid_d   = 1'b1;
      d_opcode_d  = q_head_nxt.op;
      d_size_d    = SIZE_W'(q_head_nxt.size);
      d_source_d  = SRC_W'(q_head_nxt.source);
      d_denied_d  = 1'b1;
      d_corrupt_d = (q_head_nxt.op == ACCESS_ACK_DATA);
      d_beat_d    = '0;
      d_last_d    = (q_head_nxt.op == ACCESS_ACK_DATA) ?
                    beat_last(SIZE_W'(q_head_nxt.size)) : '0;
    end
  end

  // D-side state and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      d_valid_q   <= 1'b0;
      d_opcode_q  <= ACCESS_ACK;
      d_size_q    <= '0;
      d_source_q  <= '0;
      d_denied_q  <= 1'b0;
      d_corrupt_q <= 1'b0;
      d_beat_q    <= '0;
      d_last_q    <= '0;
    end else begin
      state_q     <= state_d;
      d_valid_q   <= d_valid_d;
      d_opcode_q  <= d_opcode_d;
      d_size_q    <= d_size_d;
      d_source_q  <= d_source_d;
      d_denied_q  <= d_denied_d;
      d_corrupt_q <= d_corrupt_d;
      d_beat_q    <= d_beat_d;
      d_last_q    <= d_last_d;
    end
  end

`ifdef TL_ERR_RESP_COUNT_EN
  logic [15:0] err_count_q, err_count_d;

  // Saturating count of enqueued requests
  always_comb begin
    err_count_d = err_count_q;
    if (q_push && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
  end

  // Counter register, cleared only by reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_count_q <= '0;
    else          err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

  assign a_ready     = a_ready_q;
  assign d_valid     = d_valid_q;
  assign d_opcode    = d_opcode_q;
  assign d_size      = d_size_q;
  assign d_source    = d_source_q;
  assign d_denied    = d_denied_q;
  assign d_corrupt   = d_corrupt_q;
  assign d_data      = '0;
  assign err_illegal = err_illegal_q;

endmodule

// File: tb/tb_tl_ul_error_responder.sv
// Directed bench for tl_ul_error_responder (DATA_W=64, DEPTH=2).
module tb_tl_ul_error_responder;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned SRC_W  = 4;
  localparam int unsigned SIZE_W = 3;
  localparam int unsigned DEPTH  = 2;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              a_valid;
  logic              a_ready;
  logic [2:0]        a_opcode;
  logic [SIZE_W-1:0] a_size;
  logic [SRC_W-1:0]  a_source;
  logic [ADDR_W-1:0] a_address;
  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic [SIZE_W-1:0] d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_denied;
  logic              d_corrupt;
  logic [DATA_W-1:0] d_data;
  logic              err_illegal;
`ifdef TL_ERR_RESP_COUNT_EN
  logic [15:0]       err_count;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  tl_ul_error_responder #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .SRC_W  (SRC_W),
    .SIZE_W (SIZE_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_opcode    (a_opcode),
    .a_size      (a_size),
    .a_source    (a_source),
    .a_address   (a_address),
    .d_valid     (d_valid),
    .d_ready     (d_ready),
    .d_opcode    (d_opcode),
    .d_size      (d_size),
    .d_source    (d_source),
    .d_denied    (d_denied),
    .d_corrupt   (d_corrupt),
    .d_data      (d_data),
    .err_illegal (err_illegal)
`ifdef TL_ERR_RESP_COUNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [SIZE_W-1:0] sz,
                         input logic [SRC_W-1:0] src);
    a_valid   = 1'b1;
    a_opcode  = op;
    a_size    = sz;
    a_source  = src;
    a_address = 32'hDEAD_0000 | 32'(src);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hs;
    logic       stall;
    logic [2:0] p_op;
    logic [3:0] p_src;
    logic       p_valid;

    reset_n   = 1'b0;
    a_valid   = 1'b0;
    a_opcode  = '0;
    a_size    = '0;
    a_source  = '0;
    a_address = '0;
    d_ready   = 1'b0;

    // Reset values
    #12;
    check("rst_a_ready", a_ready, 0);
    check("rst_d_valid", d_valid, 0);
    check("rst_d_opcode", d_opcode, 0);
    check("rst_d_size", d_size, 0);
    check("rst_d_source", d_source, 0);
    check("rst_d_data", d_data, 0);
    check("rst_err_illegal", err_illegal, 0);
    reset_n = 1'b1;
    tick;
    check("post_rst_a_ready", a_ready, 1);

    // Single-beat Get, size 3, source 5
    d_ready = 1'b1;
    drive_a(3'd4, 3'd3, 4'd5);
    tick;
    a_valid = 1'b0;
    check("get1_valid", d_valid, 1);
    check("get1_opcode", d_opcode, 1);
    check("get1_denied", d_denied, 1);
    check("get1_corrupt", d_corrupt, 1);
    check("get1_data", d_data, 0);
    check("get1_source", d_source, 5);
    check("get1_size", d_size, 3);
    check("get1_err", err_illegal, 0);
    tick;
    check("get1_done", d_valid, 0);

    // Get size 6: 8 data beats with d_ready toggling
    d_ready = 1'b0;
    drive_a(3'd4, 3'd6, 4'd7);
    tick;
    a_valid = 1'b0;
    hs = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      d_ready = cyc[0];
      if (d_valid && d_ready) begin
        hs++;
        check("get8_beat_op", d_opcode, 1);
      end
      stall   = d_valid & ~d_ready;
      p_valid = d_valid;
      p_op    = d_opcode;
      p_src   = d_source;
      tick;
      if (stall) begin
        check("get8_stall_valid", d_valid, p_valid);
        check("get8_stall_op", d_opcode, p_op);
        check("get8_stall_src", d_source, p_src);
      end
    end
    check("get8_handshakes", hs, 8);
    check("get8_done", d_valid, 0);

    // PutFull size 5: four A beats, one AccessAck after the last
    d_ready = 1'b1;
    drive_a(3'd0, 3'd5, 4'd9);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin
        a_size   = 3'd0;
        a_source = 4'd3;
      end
      check("put_a_ready", a_ready, 1);
      tick;
      if (b < 3) check("put_no_early_resp", d_valid, 0);
    end
    a_valid = 1'b0;
    check("put_valid", d_valid, 1);
    check("put_opcode", d_opcode, 0);
    check("put_corrupt", d_corrupt, 0);
    check("put_denied", d_denied, 1);
    check("put_source", d_source, 9);
    check("put_size", d_size, 5);
    tick;
    check("put_single_beat", d_valid, 0);

    // Backpressure with DEPTH=2: third Get waits for the first dequeue
    d_ready = 1'b0;
    drive_a(3'd4, 3'd3, 4'd1);
    tick;
    check("bp_rdy_after1", a_ready, 1);
    drive_a(3'd4, 3'd3, 4'd2);
    tick;
    check("bp_rdy_after2", a_ready, 0);
    check("bp_head_src1", d_source, 1);
    drive_a(3'd4, 3'd3, 4'd3);
    tick;
    check("bp_still_full", a_ready, 0);
    check("bp_hold_src1", d_source, 1);
    d_ready = 1'b1;
    tick;
    check("bp_rdy_after_deq", a_ready, 1);
    check("bp_src2_valid", d_valid, 1);
    check("bp_src2", d_source, 2);
    tick;
    a_valid = 1'b0;
    check("bp_src3_valid", d_valid, 1);
    check("bp_src3", d_source, 3);
    tick;
    check("bp_done", d_valid, 0);

    // Illegal opcode 6, source 2
    drive_a(3'd6, 3'd3, 4'd2);
    tick;
    a_valid = 1'b0;
    check("ill_err_pulse", err_illegal, 1);
    check("ill_valid", d_valid, 1);
    check("ill_opcode", d_opcode, 0);
    check("ill_corrupt", d_corrupt, 0);
    check("ill_source", d_source, 2);
`ifdef TL_ERR_RESP_COUNT_EN
    check("ill_err_count", err_count, 7);
`endif
    tick;
    check("ill_err_clear", err_illegal, 0);
    check("ill_done", d_valid, 0);

    // Reset in the middle of an 8-beat response
    drive_a(3'd4, 3'd6, 4'd4);
    tick;
    a_valid = 1'b0;
    tick;
    tick;
    check("rst_mid_pre", d_valid, 1);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_mid_valid", d_valid, 0);
    check("rst_mid_a_ready", a_ready, 0);
    check("rst_mid_opcode", d_opcode, 0);
    @(negedge clock);
    reset_n = 1'b1;
    tick;
    check("rst_mid_rdy", a_ready, 1);
    check("rst_mid_empty0", d_valid, 0);
    tick;
    tick;
    check("rst_mid_empty2", d_valid, 0);
`ifdef TL_ERR_RESP_COUNT_EN
    check("rst_mid_count", err_count, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
